// File: rtl/tsmp_nm_pkg.sv
// Shared definitions for the TSMP network-management ack path.
// ack_word_t is the 66-bit typed command-ack word: {type[1:0], payload[63:0]}.
// Class index convention: CLS_WR = 0, CLS_RD = 1. The index equals the low bit
// of the ack type.
package tsmp_nm_pkg;

    localparam int ACK_W      = 66;
    localparam int ACK_DATA_W = 64;
    localparam int NUM_CLS    = 2;

    localparam logic [1:0] ACK_TYPE_RD = 2'b11;
    localparam logic [1:0] ACK_TYPE_WR = 2'b10;

    localparam int CLS_WR = 0;
    localparam int CLS_RD = 1;

    typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;

    typedef struct packed {
        logic [1:0]            typ;
        logic [ACK_DATA_W-1:0] data;
    } ack_word_t;

    // Maps an ack class to its wire type code.
    function automatic logic [1:0] cls_type(input grant_e g);
        return (g == GNT_RD) ? ACK_TYPE_RD : ACK_TYPE_WR;
    endfunction

endpackage

// File: rtl/ack_sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is read combinationally from the
// storage array.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (flushes pointers/count)
//   i_wr, iv_wdata        push strobe and data
//   i_rd                  pop strobe (ignored while empty)
//   ov_rdata              head word (valid when !o_empty)
//   o_full, o_empty       flags derived from the registered count
//   o_ovf                 push attempted while full with no same-cycle pop
module ack_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] iv_wdata,
    input  logic         i_rd,
    output logic [W-1:0] ov_rdata,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_ovf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_en, rd_en;

    assign o_full   = (count == DEPTH_C);
    assign o_empty  = (count == '0);
    assign rd_en    = i_rd && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign wr_en    = i_wr && (!o_full || rd_en);
    assign o_ovf    = i_wr && !wr_en;
    assign ov_rdata = mem[rd_ptr];

    // Storage is not reset; pointer/count reset is enough to flush it.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= iv_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/command_ack_encap.sv
// Command-ack encapsulation. Read and write ack results are buffered in one
// FIFO per class, then merged round-robin into a single 66-bit typed stream
// {type, payload}. Read acks carry type 2'b11 and write acks carry type 2'b10.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   iv_rd_ack_data, i_rd_ack_wr     read-ack push
//   iv_wr_ack_data, i_wr_ack_wr     write-ack push
//   i_ack_ready                     downstream accepts a word this edge
//   ov_command_ack, o_command_ack_wr  registered typed word + 1-cycle valid
//   o_rd_fifo_full, o_wr_fifo_full  per-class FIFO full flags
//   ov_drop_cnt                     saturating count of words dropped on full
module command_ack_encap
    import tsmp_nm_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ACK_DATA_W-1:0] iv_rd_ack_data,
    input  logic                  i_rd_ack_wr,
    input  logic [ACK_DATA_W-1:0] iv_wr_ack_data,
    input  logic                  i_wr_ack_wr,
    input  logic                  i_ack_ready,
    output logic [ACK_W-1:0]      ov_command_ack,
    output logic                  o_command_ack_wr,
    output logic                  o_rd_fifo_full,
    output logic                  o_wr_fifo_full,
    output logic [DROP_CNT_W-1:0] ov_drop_cnt
);

    logic [NUM_CLS-1:0][ACK_DATA_W-1:0] push_data, head_data;
    logic [NUM_CLS-1:0]                 push, pop, full, empty, ovf;

    assign push_data[CLS_RD] = iv_rd_ack_data;
    assign push_data[CLS_WR] = iv_wr_ack_data;
    assign push[CLS_RD]      = i_rd_ack_wr;
    assign push[CLS_WR]      = i_wr_ack_wr;

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_fifo
        ack_sync_fifo #(
            .W     (ACK_DATA_W),
            .DEPTH (FIFO_DEPTH),
            .AW    (FIFO_AW)
        ) u_fifo (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_wr     (push[c]),
            .iv_wdata (push_data[c]),
            .i_rd     (pop[c]),
            .ov_rdata (head_data[c]),
            .o_full   (full[c]),
            .o_empty  (empty[c]),
            .o_ovf    (ovf[c])
        );
    end

    assign o_rd_fifo_full = full[CLS_RD];
    assign o_wr_fifo_full = full[CLS_WR];

    // Round-robin arbiter
    grant_e last_grant;
    grant_e gnt_cls;
    logic   grant;

    always_comb begin
        grant   = i_ack_ready && (empty != '1);
        gnt_cls = GNT_WR;
        if (!empty[CLS_RD] && !empty[CLS_WR])
            gnt_cls = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
        else if (!empty[CLS_RD])
            gnt_cls = GNT_RD;
        pop         = '0;
        pop[gnt_cls] = grant;
    end

    // Output register: zeroed on every cycle without a grant
    ack_word_t out_q;
    logic      vld_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q      <= '0;
            vld_q      <= 1'b0;
            last_grant <= GNT_WR;
        end else if (grant) begin
            out_q.typ  <= cls_type(gnt_cls);
            out_q.data <= head_data[gnt_cls];
            vld_q      <= 1'b1;
            last_grant <= gnt_cls;
        end else begin
            out_q <= '0;
            vld_q <= 1'b0;
        end
    end

    assign ov_command_ack   = out_q;
    assign o_command_ack_wr = vld_q;

    // Saturating drop counter; both classes can drop in the same cycle.
    // The extra top bit of drop_sum catches wrap past all-ones.
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt;

    assign drop_sum = {1'b0, drop_cnt}
                    + (DROP_CNT_W+1)'(ovf[CLS_RD])
                    + (DROP_CNT_W+1)'(ovf[CLS_WR]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            drop_cnt <= '0;
        else if (drop_sum[DROP_CNT_W])
            drop_cnt <= '1;
        else
            drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end

    assign ov_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_command_ack_encap.sv
module tb_command_ack_encap;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] iv_rd_ack_data, iv_wr_ack_data;
    logic        i_rd_ack_wr, i_wr_ack_wr, i_ack_ready;
    logic [65:0] ov_command_ack;
    logic        o_command_ack_wr, o_rd_fifo_full, o_wr_fifo_full;
    logic [15:0] ov_drop_cnt;

    int total = 0;
    int bad   = 0;

    command_ack_encap #(.FIFO_DEPTH(8), .FIFO_AW(3), .DROP_CNT_W(16)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .iv_rd_ack_data   (iv_rd_ack_data),
        .i_rd_ack_wr      (i_rd_ack_wr),
        .iv_wr_ack_data   (iv_wr_ack_data),
        .i_wr_ack_wr      (i_wr_ack_wr),
        .i_ack_ready      (i_ack_ready),
        .ov_command_ack   (ov_command_ack),
        .o_command_ack_wr (o_command_ack_wr),
        .o_rd_fifo_full   (o_rd_fifo_full),
        .o_wr_fifo_full   (o_wr_fifo_full),
        .ov_drop_cnt      (ov_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [65:0] exp_ack, input logic exp_wr);
        total++;
        if (ov_command_ack !== exp_ack || o_command_ack_wr !== exp_wr) begin
            bad++;
            $display("FAIL %s: got ack=%h wr=%b, want ack=%h wr=%b",
                     name, ov_command_ack, o_command_ack_wr, exp_ack, exp_wr);
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_rd_ack_wr = 1'b0; i_wr_ack_wr = 1'b0; i_ack_ready = 1'b0;
        iv_rd_ack_data = '0; iv_wr_ack_data = '0;
        step(); step();
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        chk_out("reset_out", 66'h0, 1'b0);
        total++;
        if (o_rd_fifo_full !== 1'b0 || o_wr_fifo_full !== 1'b0 || ov_drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_flags: got rdf=%b wrf=%b drop=%0d, want 0 0 0",
                     o_rd_fifo_full, o_wr_fifo_full, ov_drop_cnt);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        i_ack_ready = 1'b1;
        iv_rd_ack_data = 64'h0123_4567_89AB_CDEF; i_rd_ack_wr = 1'b1;
        step();
        i_rd_ack_wr = 1'b0;
        chk_out("single_n", 66'h0, 1'b0);
        step();
        chk_out("single_n1", {2'b11, 64'h0123_4567_89AB_CDEF}, 1'b1);
        step();
        chk_out("single_n2", 66'h0, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_ack_ready = 1'b1;
        iv_rd_ack_data = 64'h1; i_rd_ack_wr = 1'b1;
        iv_wr_ack_data = 64'h2; i_wr_ack_wr = 1'b1;
        step();
        i_rd_ack_wr = 1'b0; i_wr_ack_wr = 1'b0;
        step();
        chk_out("simul_rd", {2'b11, 64'h1}, 1'b1);
        step();
        chk_out("simul_wr", {2'b10, 64'h2}, 1'b1);
        step();
        chk_out("simul_idle", 66'h0, 1'b0);
    endtask

    task automatic test_alternation();
        logic [65:0] exp_seq [6];
        exp_seq = '{{2'b11, 64'h10}, {2'b10, 64'h20}, {2'b11, 64'h11},
                    {2'b10, 64'h21}, {2'b11, 64'h12}, {2'b10, 64'h22}};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            iv_rd_ack_data = 64'h10 + 64'(i); i_rd_ack_wr = 1'b1;
            iv_wr_ack_data = 64'h20 + 64'(i); i_wr_ack_wr = 1'b1;
            step();
        end
        i_rd_ack_wr = 1'b0; i_wr_ack_wr = 1'b0;
        step();
        chk_out("alt_held", 66'h0, 1'b0);
        i_ack_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_out($sformatf("alt_%0d", i), exp_seq[i], 1'b1);
        end
        step();
        chk_out("alt_idle", 66'h0, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            iv_rd_ack_data = 64'hA00 + 64'(i); i_rd_ack_wr = 1'b1;
            step();
            if (i == 6) begin
                total++;
                if (o_rd_fifo_full !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_full7: got %b want 0", o_rd_fifo_full);
                end
            end
            if (i == 7) begin
                total++;
                if (o_rd_fifo_full !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_full8: got %b want 1", o_rd_fifo_full);
                end
            end
        end
        i_rd_ack_wr = 1'b0;
        total++;
        if (ov_drop_cnt !== 16'd2) begin
            bad++;
            $display("FAIL ovf_drop: got %0d want 2", ov_drop_cnt);
        end
        i_ack_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("ovf_out_%0d", i), {2'b11, 64'hA00 + 64'(i)}, 1'b1);
        end
        step();
        chk_out("ovf_idle", 66'h0, 1'b0);
        total++;
        if (o_rd_fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL ovf_unfull: got %b want 0", o_rd_fifo_full);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iv_rd_ack_data = 64'h50 + 64'(i); i_rd_ack_wr = 1'b1;
            step();
        end
        // Pop and push at the same edge while full
        i_ack_ready = 1'b1;
        iv_rd_ack_data = 64'h99; i_rd_ack_wr = 1'b1;
        step();
        i_rd_ack_wr = 1'b0;
        chk_out("fpp_first", {2'b11, 64'h50}, 1'b1);
        total++;
        if (o_rd_fifo_full !== 1'b1 || ov_drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL fpp_flags: got full=%b drop=%0d want full=1 drop=0",
                     o_rd_fifo_full, ov_drop_cnt);
        end
        for (int i = 1; i < 8; i++) begin
            step();
            chk_out($sformatf("fpp_%0d", i), {2'b11, 64'h50 + 64'(i)}, 1'b1);
        end
        step();
        chk_out("fpp_pushed", {2'b11, 64'h99}, 1'b1);
        step();
        chk_out("fpp_idle", 66'h0, 1'b0);
    endtask

    task automatic test_reset_flush();
        int seen;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            iv_wr_ack_data = 64'hB0 + 64'(i); i_wr_ack_wr = 1'b1;
            iv_rd_ack_data = 64'hC0 + 64'(i); i_rd_ack_wr = (i < 5);
            step();
        end
        i_rd_ack_wr = 1'b0; i_wr_ack_wr = 1'b0;
        total++;
        if (ov_drop_cnt !== 16'd1) begin
            bad++;
            $display("FAIL flush_predrop: got %0d want 1", ov_drop_cnt);
        end
        i_ack_ready = 1'b1;
        step();
        chk_out("flush_pre", {2'b11, 64'hC0}, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk_out("flush_async", 66'h0, 1'b0);
        total++;
        if (ov_drop_cnt !== 16'd0 || o_wr_fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL flush_flags: got drop=%0d wrf=%b want 0 0", ov_drop_cnt, o_wr_fifo_full);
        end
        step();
        i_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_command_ack_wr === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || ov_drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL flush_after: got emissions=%0d drop=%0d want 0 0", seen, ov_drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_alternation();
        test_overflow();
        test_full_push_pop();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/command_ack_encap.md
Name: command_ack_encap

Overview:
- Transmit-side counterpart of the command-ack type parser in the TSMP agent network-management path.
- Collects 64-bit read-ack and write-ack results from the local register/table access logic.
- Buffers each class in its own FIFO and arbitrates round-robin between them.
- Emits a single 66-bit typed command-ack stream: [65:64] = ack type, [63:0] = payload. This stream feeds the ack encapsulation toward the NMAC.

Parameters:
- FIFO_DEPTH, 8: entries per class FIFO; must be a power of two, ≥2.
- FIFO_AW, 3: log2(FIFO_DEPTH).
- DROP_CNT_W, 16: width of the drop counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- iv_rd_ack_data  in  64  read-ack payload
- i_rd_ack_wr  in  1  read-ack write strobe, one word per cycle
- iv_wr_ack_data  in  64  write-ack payload
- i_wr_ack_wr  in  1  write-ack write strobe
- i_ack_ready  in  1  downstream can accept a word on the next edge
- ov_command_ack  out  66  typed ack word
- o_command_ack_wr  out  1  ov_command_ack valid, single-cycle pulse per word
- o_rd_fifo_full  out  1  read FIFO full
- o_wr_fifo_full  out  1  write FIFO full
- ov_drop_cnt  out  DROP_CNT_W  count of words dropped on a full FIFO, saturating

Behaviour:
- Reset values:
  - ov_command_ack = 0, o_command_ack_wr = 0, ov_drop_cnt = 0.
  - Both FIFOs empty; o_*_fifo_full = 0.
  - last_grant = WR, so read wins the first contention.
- Reset mid-operation flushes all FIFO contents. Nothing is emitted until new strobes arrive.
- Push:
  - On a strobe with the FIFO not full, the word is written at that edge.
  - On a strobe with the FIFO full, the word is dropped and ov_drop_cnt increments by 1, saturating at all-ones.
  - If both FIFOs drop in the same cycle, ov_drop_cnt increments by 2, still saturating.
- Full flags come from registered counts and reflect occupancy after the edge.
- FIFOs are show-ahead: the head word is readable combinationally from the storage array.
- Arbitration, evaluated every cycle. A grant occurs when i_ack_ready = 1 and at least one FIFO is non-empty:
  - Only read non-empty: grant RD.
  - Only write non-empty: grant WR.
  - Both non-empty: grant the class not equal to last_grant.
  - last_grant updates on every grant.
- Emission:
  - On a grant at edge N, pop the head of the granted FIFO.
  - After edge N: ov_command_ack = {type, head}, with type = 2'b11 for RD and 2'b10 for WR; o_command_ack_wr = 1.
  - In a cycle with no grant, the next edge drives ov_command_ack = 0 and o_command_ack_wr = 0. Zeroing is mandatory.
  - Types 2'b00 and 2'b01 are never emitted.
- Latency: a strobe at edge N into an empty FIFO, with i_ack_ready high, gives the output word after edge N+1 (1-cycle latency).
- Throughput: 1 word per cycle while ready.
- A push and pop on the same FIFO in one cycle is legal:
  - Count is unchanged.
  - When the FIFO is full, the simultaneous push is accepted (pop frees the slot) and is not counted as a drop.
- When i_ack_ready = 0, no pop occurs and FIFO contents are held. Pushes continue until full.
- Pointers are FIFO_AW bits wide and wrap naturally. The count is FIFO_AW+1 bits.
- Word order within a class is strictly preserved. There is no ordering guarantee across classes beyond the round-robin rule.

Decomposition:
- Shared package (tsmp_nm_pkg):
  - ACK_TYPE_RD = 2'b11
  - ACK_TYPE_WR = 2'b10
  - ACK_W = 66
  - ACK_DATA_W = 64
- Sub-module ack_sync_fifo:
  - Parameterised width and depth; show-ahead, single clock.
  - Outputs: full, empty, overflow-attempt.
  - Instantiated twice, once for RD and once for WR.
- Arbiter, output register and drop counter stay in the top module.

Test Plan:
- Single read ack, ready = 1: strobe at N with 0x0123_4567_89AB_CDEF -> after N+1, ov_command_ack = {2'b11, 0x0123456789ABCDEF} and wr = 1 for exactly 1 cycle; then 0.
- Simultaneous read A=0x1 and write B=0x2 at N from reset, ready = 1 -> outputs {11,0x1} then {10,0x2} on consecutive cycles.
- Alternation: 3 reads and 3 writes queued with ready low, then ready raised -> RD, WR, RD, WR, RD, WR order; payloads in FIFO order.
- Backpressure/overflow with ready = 0: push 10 reads -> o_rd_fifo_full = 1 after the 8th; ov_drop_cnt = 2. Then raise ready -> exactly the first 8 words are emitted in order.
- Full FIFO, ready = 1, push in the same cycle as the pop -> push accepted, no drop, count stays 8.
- Reset asserted with 5 words queued -> outputs zero immediately. After release there is no emission, and ov_drop_cnt = 0.
